// File: rtl/video_rd_scheduler_if.sv
// video_rd_scheduler_if: burst read request/acknowledge bus between scheduler and memory reader
interface video_rd_scheduler_if;
    logic        rd_req;
    logic [27:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_ack;
    logic        rd_done;
    modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_done);
    modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_done);
endinterface

// File: rtl/video_rd_scheduler.sv
// video_rd_scheduler: issues frame-buffer read bursts into the line FIFO, one frame per vsync
module video_rd_scheduler #(
    parameter int          H_DISP     = 1280,
    parameter int          V_DISP     = 720,
    parameter int          BURST_LEN  = 128,
    parameter int          FIFO_DEPTH = 2048,
    parameter logic [27:0] BANK0_BASE = 28'h000_0000,
    parameter logic [27:0] BANK1_BASE = 28'h010_0000
) (
    input  logic                        pixel_clk,
    input  logic                        sys_rst,
    input  logic                        video_vs,
    input  logic                        frame_done_wr,
    input  logic [11:0]                 fifo_level,
    video_rd_scheduler_if.master        rd,
    output logic                        fifo_clr,
    output logic                        rd_bank,
    output logic                        frame_err,
    input  logic                        err_clr
);
    localparam logic [12:0] NBURST = 13'(H_DISP * V_DISP / BURST_LEN);

    typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        vs_q, vs_d;
    logic        fs_pend_q, fs_pend_d;
    logic        swap_q, swap_d;
    logic        bank_q, bank_d;
    logic        err_q, err_d;
    logic [12:0] idx_q, idx_d;
    logic [12:0] left_q, left_d;
    logic        apply, room, step;

    // a pending frame start is only taken when no burst is outstanding
    assign apply = fs_pend_q && (state_q == IDLE || state_q == CHECK || state_q == DONE);
    assign room  = ({1'b0, fifo_level} + 13'(BURST_LEN)) <= 13'(FIFO_DEPTH);
    assign step  = state_q == WAIT && rd.rd_done;

    assign rd_bank   = bank_q;
    assign frame_err = err_q;

    // state and datapath registers
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            vs_q      <= 1'b1;
            fs_pend_q <= 1'b0;
            swap_q    <= 1'b0;
            bank_q    <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            left_q    <= '0;
        end else begin
            state_q   <= state_d;
            vs_q      <= vs_d;
            fs_pend_q <= fs_pend_d;
            swap_q    <= swap_d;
            bank_q    <= bank_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            left_q    <= left_d;
        end
    end

    // next state: FSM transitions plus burst counters, pending flags and sticky error
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = apply ? CHECK : state_q;
            CHECK:      state_d = apply ? CHECK : (left_q == '0) ? DONE : room ? REQ : CHECK;
            REQ:        state_d = rd.rd_ack ? WAIT : REQ;
            WAIT:       state_d = rd.rd_done ? CHECK : WAIT;
            default:    state_d = IDLE;
        endcase
        vs_d      = video_vs;
        fs_pend_d = (vs_q && !video_vs) || (fs_pend_q && !apply);
        swap_d    = frame_done_wr || (swap_q && !apply);
        bank_d    = bank_q ^ (apply && swap_q);
        err_d     = (apply && state_q != IDLE && left_q != '0) || (err_q && !err_clr);
        idx_d     = apply ? 13'd0 : idx_q + 13'(step);
        left_d    = apply ? NBURST : left_q - 13'(step);
    end

    // outputs: request bus held stable throughout REQ, flush pulse on frame start
    always_comb begin
        rd.rd_req  = state_q == REQ;
        rd.rd_addr = (state_q == REQ) ? (bank_q ? BANK1_BASE : BANK0_BASE) + 28'(idx_q) * 28'(BURST_LEN) : 28'd0;
        rd.rd_len  = 8'(BURST_LEN);
        fifo_clr   = apply;
    end
endmodule

// File: tb/tb_video_rd_scheduler.sv
// tb_video_rd_scheduler: directed scenarios with a request scoreboard for video_rd_scheduler
module tb_video_rd_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        video_vs = 1'b1;
    logic        frame_done_wr = 1'b0;
    logic        err_clr = 1'b0;
    logic [11:0] fifo_level = 12'd0;
    logic        fifo_clr, rd_bank, frame_err;

    video_rd_scheduler_if rif();

    video_rd_scheduler dut (
        .pixel_clk    (clk),
        .sys_rst      (rst),
        .video_vs     (video_vs),
        .frame_done_wr(frame_done_wr),
        .fifo_level   (fifo_level),
        .rd           (rif),
        .fifo_clr     (fifo_clr),
        .rd_bank      (rd_bank),
        .frame_err    (frame_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int hs_cnt = 0, clr_cnt = 0, req_cyc = 0;
    int ack_lim = 0, hold_at = -1, ack_dly = 0, done_dly = 0;
    logic [27:0] exp_q[$];
    logic [27:0] exp_e, prev_addr;
    logic        prev_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: scoreboard pop on every accepted request, request stability, flush counting
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (fifo_clr) clr_cnt++;
            if (rif.rd_req) begin
                req_cyc++;
                if (prev_req) chk("addr_stable", rif.rd_addr, prev_addr);
            end
            prev_req  = rif.rd_req;
            prev_addr = rif.rd_addr;
            if (rif.rd_req && rif.rd_ack) begin
                hs_cnt++;
                if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
                else begin
                    exp_e = exp_q.pop_front();
                    chk("rd_addr", rif.rd_addr, exp_e);
                    chk("rd_len", rif.rd_len, 128);
                end
            end
        end else prev_req = 1'b0;
    end

    // memory reader model: ack and done after programmable delays, limited to ack_lim bursts
    initial begin
        rif.rd_ack  = 1'b0;
        rif.rd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && rif.rd_req && hs_cnt < ack_lim) begin
                repeat (ack_dly) @(negedge clk);
                rif.rd_ack = 1'b1;
                @(negedge clk);
                rif.rd_ack = 1'b0;
                repeat (done_dly) @(negedge clk);
                while (hs_cnt == hold_at) @(negedge clk);
                rif.rd_done = 1'b1;
                @(negedge clk);
                rif.rd_done = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        ack_lim = hs_cnt;
        hold_at = -1;
        exp_q.delete();
        video_vs = 1'b1;
        frame_done_wr = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req", rif.rd_req, 0);
        chk("rst_addr", rif.rd_addr, 0);
        chk("rst_len", rif.rd_len, 128);
        chk("rst_clr", fifo_clr, 0);
        chk("rst_bank", rd_bank, 0);
        chk("rst_err", frame_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_start(input logic fdw);
        @(negedge clk);
        video_vs = 1'b0;
        @(negedge clk);
        frame_done_wr = fdw;
        @(negedge clk);
        frame_done_wr = 1'b0;
        repeat (3) @(negedge clk);
        video_vs = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_hs(input int n, input int lim);
        int c = 0;
        while (hs_cnt < n && c < lim) begin
            @(negedge clk);
            #2;
            c++;
        end
        chk("hs_wait_timeout", 32'(hs_cnt >= n), 1);
    endtask

    initial begin
        int h0, c0, r0;
        // first frame: flush, two bursts at 0x0 and 0x80, then reset mid-request
        do_reset();
        ack_dly = 2;
        done_dly = 2;
        r0 = req_cyc;
        repeat (100) @(negedge clk);
        chk("A_idle_no_req", req_cyc - r0, 0);
        c0 = clr_cnt;
        h0 = hs_cnt;
        exp_q.push_back(28'h0000000);
        exp_q.push_back(28'h0000080);
        ack_lim = h0 + 2;
        frame_start(1'b0);
        wait_hs(h0 + 2, 200);
        chk("A_clr_pulse", clr_cnt - c0, 1);
        chk("A_err", frame_err, 0);
        repeat (10) @(negedge clk);
        chk("A_third_pending", rif.rd_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("A_async_rst_req", rif.rd_req, 0);
        chk("A_async_rst_addr", rif.rd_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r0 = req_cyc;
        repeat (50) @(negedge clk);
        chk("A_no_req_after_rst", req_cyc - r0, 0);

        // FIFO room threshold: 1921 stalls, 1920 releases
        do_reset();
        ack_dly = 0;
        done_dly = 0;
        fifo_level = 12'd1921;
        h0 = hs_cnt;
        exp_q.push_back(28'h0000000);
        ack_lim = h0 + 1;
        frame_start(1'b0);
        repeat (20) @(negedge clk);
        chk("B_stall_req", rif.rd_req, 0);
        chk("B_stall_hs", hs_cnt - h0, 0);
        fifo_level = 12'd1920;
        @(negedge clk);
        #2;
        chk("B_req_next", rif.rd_req, 1);
        fifo_level = 12'd2047;
        wait_hs(h0 + 1, 50);
        repeat (10) @(negedge clk);
        chk("B_full_no_req", rif.rd_req, 0);

        // bank swap, with a writer completion coincident with the frame start
        do_reset();
        done_dly = 2;
        fifo_level = 12'd2047;
        @(negedge clk);
        frame_done_wr = 1'b1;
        @(negedge clk);
        frame_done_wr = 1'b0;
        frame_start(1'b1);
        chk("C_bank1", rd_bank, 1);
        h0 = hs_cnt;
        exp_q.push_back(28'h0100000);
        ack_lim = h0 + 1;
        fifo_level = 12'd0;
        wait_hs(h0 + 1, 50);
        fifo_level = 12'd2047;
        frame_start(1'b0);
        chk("C_bank_toggle_again", rd_bank, 0);
        frame_start(1'b0);
        chk("C_bank_stays", rd_bank, 0);

        // frame start during WAIT with 7000 bursts left
        do_reset();
        done_dly = 0;
        fifo_level = 12'd0;
        h0 = hs_cnt;
        for (int i = 0; i < 201; i++) exp_q.push_back(28'(i * 128));
        ack_lim = h0 + 202;
        hold_at = h0 + 201;
        frame_start(1'b0);
        wait_hs(h0 + 201, 2000);
        c0 = clr_cnt;
        frame_start(1'b0);
        repeat (10) @(negedge clk);
        chk("D_no_clr_in_wait", clr_cnt - c0, 0);
        chk("D_err_before", frame_err, 0);
        chk("D_no_req_in_wait", rif.rd_req, 0);
        exp_q.push_back(28'h0000000);
        hold_at = -1;
        wait_hs(h0 + 202, 50);
        chk("D_clr_after_done", clr_cnt - c0, 1);
        chk("D_err_set", frame_err, 1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #2;
        chk("D_err_cleared", frame_err, 0);

        // complete frame of 7200 bursts, idle in DONE, restart on next frame
        do_reset();
        fifo_level = 12'd0;
        h0 = hs_cnt;
        for (int i = 0; i < 7200; i++) exp_q.push_back(28'(i * 128));
        ack_lim = h0 + 7200;
        frame_start(1'b0);
        wait_hs(h0 + 7200, 30000);
        repeat (20) @(negedge clk);
        r0 = req_cyc;
        repeat (50) @(negedge clk);
        chk("E_done_no_req", req_cyc - r0, 0);
        chk("E_err", frame_err, 0);
        chk("E_queue_empty", exp_q.size(), 0);
        h0 = hs_cnt;
        exp_q.push_back(28'h0000000);
        ack_lim = h0 + 1;
        frame_start(1'b0);
        wait_hs(h0 + 1, 50);
        chk("E_err_restart", frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
